// File: rtl/cpu_pkg.sv
// Shared encodings for the ExceptioNull control sequencer: opcodes, FSM states,
// ALU operation codes and the write-back / next-PC source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_JAL  = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_ADDI = 4'b1110;
  localparam logic [3:0] OP_LI   = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] DMUX_ALU = 2'b00;
  localparam logic [1:0] DMUX_MEM = 2'b01;
  localparam logic [1:0] DMUX_PC1 = 2'b10;
  localparam logic [1:0] DMUX_IMM = 2'b11;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Opcodes 0000-0111 are register-register ALU ops whose low bits are the ALU code.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Purely combinational opcode decoder: maps ir[7:4] to the per-instruction
// control fields used by the sequencer in EXEC, MEM and WB.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_control,
  output logic       alu_mux_select,
  output logic [1:0] dmux_select,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       writes_reg
);

  // Opcode-to-control table.
  always_comb begin
    alu_control    = ALU_ADD;
    alu_mux_select = 1'b0;
    dmux_select    = DMUX_ALU;
    is_mem         = 1'b0;
    is_store       = 1'b0;
    is_branch      = 1'b0;
    is_jump        = 1'b0;
    writes_reg     = 1'b0;
    if (is_rtype(op)) begin
      alu_control = op[2:0];
      writes_reg  = 1'b1;
    end else begin
      case (op)
        OP_J: begin
          is_jump = 1'b1;
        end
        OP_JAL: begin
          is_jump     = 1'b1;
          writes_reg  = 1'b1;
          dmux_select = DMUX_PC1;
        end
        OP_LW: begin
          alu_mux_select = 1'b1;
          is_mem         = 1'b1;
          writes_reg     = 1'b1;
          dmux_select    = DMUX_MEM;
        end
        OP_SW: begin
          alu_mux_select = 1'b1;
          is_mem         = 1'b1;
          is_store       = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          alu_control = ALU_SUB;
          is_branch   = 1'b1;
        end
        OP_ADDI: begin
          alu_mux_select = 1'b1;
          writes_reg     = 1'b1;
        end
        OP_LI: begin
          alu_mux_select = 1'b1;
          writes_reg     = 1'b1;
          dmux_select    = DMUX_IMM;
        end
        default: begin
          alu_control = ALU_ADD;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns the instruction register, walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and guards both memories with a watchdog.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       dmem_req,
  input  logic       dmem_ack,
  output logic       data_mem_wren,
  input  logic       alu_zero,
  output logic [2:0] alu_control,
  output logic       alu_mux_select,
  output logic       reg_file_wren,
  output logic [1:0] reg_file_dmux_select,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic [7:0] ir,
  output logic [2:0] state,
  output logic       instr_retired,
  output logic       fault
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_r;
  state_t           next_state_s;
  state_t           retire_state_s;
  logic [7:0]       ir_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic       req_s;
  logic       ack_s;
  logic       wait_expired_s;
  logic       cnt_clear_s;
  logic       short_exec_s;

  logic [2:0] dec_alu_control_s;
  logic       dec_alu_mux_select_s;
  logic [1:0] dec_dmux_select_s;
  logic       dec_is_mem_s;
  logic       dec_is_store_s;
  logic       dec_is_branch_s;
  logic       dec_is_jump_s;
  logic       dec_writes_reg_s;

  seq_decode u_decode (
    .op             (ir_r[7:4]),
    .alu_control    (dec_alu_control_s),
    .alu_mux_select (dec_alu_mux_select_s),
    .dmux_select    (dec_dmux_select_s),
    .is_mem         (dec_is_mem_s),
    .is_store       (dec_is_store_s),
    .is_branch      (dec_is_branch_s),
    .is_jump        (dec_is_jump_s),
    .writes_reg     (dec_writes_reg_s)
  );

  // j, beq and bne finish in EXEC; jal still has a link write-back to do.
  assign short_exec_s   = dec_is_branch_s || (dec_is_jump_s && !dec_writes_reg_s);
  assign retire_state_s = run ? ST_FETCH : ST_IDLE;

  // The watchdog only ever observes the memory owned by the current state.
  assign req_s          = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign ack_s          = (state_r == ST_FETCH) ? imem_ack : dmem_ack;
  assign wait_expired_s = (wait_cnt_r == CNT_LIMIT) && !ack_s;
  assign cnt_clear_s    = (next_state_s != state_r) &&
                          ((next_state_s == ST_FETCH) || (next_state_s == ST_MEM));

  assign state = state_r;
  assign ir    = ir_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          next_state_s = ST_DECODE;
        end else if (wait_expired_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        next_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (short_exec_s) begin
          next_state_s = retire_state_s;
        end else if (dec_is_mem_s) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (dec_is_store_s) begin
            next_state_s = retire_state_s;
          end else begin
            next_state_s = ST_WB;
          end
        end else if (wait_expired_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        next_state_s = retire_state_s;
      end
      ST_FAULT: begin
        next_state_s = ST_FAULT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from state, IR and the same-cycle ack / zero inputs.
  always_comb begin
    imem_req             = 1'b0;
    dmem_req             = 1'b0;
    data_mem_wren        = 1'b0;
    alu_control          = ALU_ADD;
    alu_mux_select       = 1'b0;
    reg_file_wren        = 1'b0;
    reg_file_dmux_select = DMUX_ALU;
    pc_wren              = 1'b0;
    pc_src               = PC_SRC_SEQ;
    instr_retired        = 1'b0;
    fault                = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req = 1'b1;
        pc_wren  = imem_ack;
        pc_src   = PC_SRC_SEQ;
      end
      ST_EXEC: begin
        alu_control    = dec_alu_control_s;
        alu_mux_select = dec_alu_mux_select_s;
        if (dec_is_jump_s) begin
          pc_wren = 1'b1;
          pc_src  = PC_SRC_JUMP;
        end else if (dec_is_branch_s) begin
          pc_src  = PC_SRC_BRANCH;
          pc_wren = (ir_r[7:4] == OP_BNE) ? !alu_zero : alu_zero;
        end else begin
          pc_wren = 1'b0;
        end
        instr_retired = short_exec_s;
      end
      ST_MEM: begin
        dmem_req      = 1'b1;
        data_mem_wren = dec_is_store_s;
        instr_retired = dec_is_store_s && dmem_ack;
      end
      ST_WB: begin
        reg_file_wren        = 1'b1;
        reg_file_dmux_select = dec_dmux_select_s;
        instr_retired        = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        fault = 1'b0;
      end
    endcase
  end

  // Instruction register, loaded on the accepted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= 8'h00;
    end else if ((state_r == ST_FETCH) && imem_ack) begin
      ir_r <= imem_rdata;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Watchdog wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (cnt_clear_s) begin
      wait_cnt_r <= '0;
    end else if (req_s && !ack_s) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer: a transaction-level model
// expands each instruction into its expected per-cycle output trace.
module tb_cpu_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       dmem_req;
  logic       dmem_ack;
  logic       data_mem_wren;
  logic       alu_zero;
  logic [2:0] alu_control;
  logic       alu_mux_select;
  logic       reg_file_wren;
  logic [1:0] reg_file_dmux_select;
  logic       pc_wren;
  logic [1:0] pc_src;
  logic [7:0] ir;
  logic [2:0] state;
  logic       instr_retired;
  logic       fault;

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk                  (clk),
    .reset                (reset),
    .run                  (run),
    .imem_req             (imem_req),
    .imem_ack             (imem_ack),
    .imem_rdata           (imem_rdata),
    .dmem_req             (dmem_req),
    .dmem_ack             (dmem_ack),
    .data_mem_wren        (data_mem_wren),
    .alu_zero             (alu_zero),
    .alu_control          (alu_control),
    .alu_mux_select       (alu_mux_select),
    .reg_file_wren        (reg_file_wren),
    .reg_file_dmux_select (reg_file_dmux_select),
    .pc_wren              (pc_wren),
    .pc_src               (pc_src),
    .ir                   (ir),
    .state                (state),
    .instr_retired        (instr_retired),
    .fault                (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ia;
    logic [7:0]  rd;
    logic        da;
    logic        z;
    logic        rn;
    logic [25:0] exp;
  } cyc_t;

  cyc_t       q[$];
  int         n_vec;
  int         n_bad;
  logic       m_idle;
  logic [7:0] last_ir;

  task automatic check_val(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] pk(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic dwr, input logic [2:0] alu, input logic mux,
                                     input logic rfw, input logic [1:0] dm, input logic pcw,
                                     input logic [1:0] pcs, input logic ret, input logic flt,
                                     input logic [7:0] irv);
    return {st, ireq, dreq, dwr, alu, mux, rfw, dm, pcw, pcs, ret, flt, irv};
  endfunction

  function automatic logic [25:0] got_vec();
    return {state, imem_req, dmem_req, data_mem_wren, alu_control, alu_mux_select,
            reg_file_wren, reg_file_dmux_select, pc_wren, pc_src, instr_retired, fault, ir};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rb8();
    return 8'($urandom);
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    if (op < 4'd8) return op[2:0];
    else if (op == 4'hC || op == 4'hD) return 3'd1;
    else return 3'd0;
  endfunction

  function automatic logic mux_of(input logic [3:0] op);
    return (op == 4'hA || op == 4'hB || op == 4'hE || op == 4'hF);
  endfunction

  function automatic logic [1:0] dmux_of(input logic [3:0] op);
    if (op == 4'hA) return 2'd1;
    else if (op == 4'h9) return 2'd2;
    else if (op == 4'hF) return 2'd3;
    else return 2'd0;
  endfunction

  task automatic push(input logic ia, input logic [7:0] rd, input logic da, input logic z,
                      input logic rn, input logic [25:0] exp);
    cyc_t c;
    c.ia = ia; c.rd = rd; c.da = da; c.z = z; c.rn = rn; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic push_fault();
    for (int k = 0; k < 4; k++)
      push(1'b1, rb8(), 1'b1, rb(), rb(),
           pk(3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, last_ir));
  endtask

  // Expected cycle trace of one instruction; wait counts of 15 or more model a timeout.
  task automatic gen(input logic [7:0] instr, input int wi, input int wd, input logic z,
                     input logic rr);
    logic [3:0] op;
    logic       short_op;
    logic       pcw;
    logic [1:0] pcs;
    int         n;
    op = instr[7:4];
    if (m_idle) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
        push(rb(), rb8(), rb(), rb(), 1'b0,
             pk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, last_ir));
      push(rb(), rb8(), rb(), rb(), 1'b1,
           pk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, last_ir));
    end
    for (int k = 0; k < ((wi >= 15) ? 15 : wi); k++)
      push(1'b0, rb8(), rb(), rb(), rb(),
           pk(3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, last_ir));
    if (wi >= 15) begin
      push_fault();
      return;
    end
    push(1'b1, instr, rb(), rb(), rb(),
         pk(3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, last_ir));
    last_ir = instr;
    push(rb(), rb8(), rb(), rb(), rb(),
         pk(3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, last_ir));
    short_op = (op == 4'h8 || op == 4'hC || op == 4'hD);
    pcw = (op == 4'h8 || op == 4'h9) ? 1'b1 : (op == 4'hC) ? z : (op == 4'hD) ? !z : 1'b0;
    pcs = (op == 4'h8 || op == 4'h9) ? 2'd2 : (op == 4'hC || op == 4'hD) ? 2'd1 : 2'd0;
    push(rb(), rb8(), rb(), z, short_op ? rr : rb(),
         pk(3'd3, 1'b0, 1'b0, 1'b0, alu_of(op), mux_of(op), 1'b0, 2'd0, pcw, pcs, short_op,
            1'b0, last_ir));
    if (short_op) begin
      m_idle = !rr;
      return;
    end
    if (op == 4'hA || op == 4'hB) begin
      for (int k = 0; k < ((wd >= 15) ? 15 : wd); k++)
        push(rb(), rb8(), 1'b0, rb(), rb(),
             pk(3'd4, 1'b0, 1'b1, op == 4'hB, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0,
                last_ir));
      if (wd >= 15) begin
        push_fault();
        return;
      end
      push(rb(), rb8(), 1'b1, rb(), (op == 4'hB) ? rr : rb(),
           pk(3'd4, 1'b0, 1'b1, op == 4'hB, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, op == 4'hB,
              1'b0, last_ir));
      if (op == 4'hB) begin
        m_idle = !rr;
        return;
      end
    end
    push(rb(), rb8(), rb(), rb(), rr,
         pk(3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, dmux_of(op), 1'b0, 2'd0, 1'b1, 1'b0,
            last_ir));
    m_idle = !rr;
  endtask

  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      imem_ack   = c.ia;
      imem_rdata = c.rd;
      dmem_ack   = c.da;
      alu_zero   = c.z;
      run        = c.rn;
      #1;
      check_val("cycle", got_vec(), c.exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; imem_rdata = 8'h00;
    #1;
    check_val("reset_outs", got_vec(), 26'd0);
    @(negedge clk);
    reset   = 1'b0;
    m_idle  = 1'b1;
    last_ir = 8'h00;
  endtask

  int wi;
  int wd;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    #2;
    do_reset();

    gen(8'h05, 0, 0, rb(), 1'b1);
    gen(8'hA4, 0, 3, rb(), 1'b1);
    gen(8'hC0, 0, 0, 1'b1, 1'b1);
    gen(8'hD0, 0, 0, 1'b1, 1'b1);
    gen(8'hB2, 0, 0, rb(), 1'b0);
    play();

    for (int i = 0; i < 60; i++) begin
      wi = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 2));
      wd = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 2));
      gen(rb8(), wi, wd, rb(), ($urandom_range(0, 3) != 0));
    end
    gen(8'h3C, 0, 0, 1'b0, 1'b1);
    play();

    // Asynchronous reset while a fetch request is outstanding.
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check_val("fetch_req_pre_rst", {25'd0, imem_req}, 26'd1);
    do_reset();

    gen(8'h47, 15, 0, 1'b0, 1'b1);
    play();
    do_reset();

    gen(8'hA4, 1, 15, 1'b0, 1'b1);
    play();
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
